// File: rtl/storage_element_bank.sv
// WIDTH-bit storage bank for the lab board: two debounced buttons and a mode switch
// emulate a transparent latch, a D flip-flop, a shift register or an up/down counter.
module storage_element_bank #(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LED_ACTIVE_LOW  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_d,
    input  logic             btn_load,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] led
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] MODE_LATCH   = 2'b00;
    localparam logic [1:0] MODE_DFF     = 2'b01;
    localparam logic [1:0] MODE_SHIFT   = 2'b10;
    localparam logic [1:0] MODE_COUNTER = 2'b11;

    // Bit order in the synchroniser vector: {mode[1:0], btn_load, btn_d}
    logic [3:0] sync_a;
    logic [3:0] sync_b;
    logic [1:0] mode_s;
    logic [1:0] db_lvl;
    logic       d_db;
    logic       ld_db;
    logic       ld_prev;
    logic       ld_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {mode, btn_load, btn_d};
            sync_b <= sync_a;
        end
    end

    assign mode_s = sync_b[3:2];

    for (genvar g = 0; g < 2; g++) begin : g_db
        logic [CNT_W-1:0] cnt;
        logic             lvl;

        // The level flips on the edge where the mismatch has lasted DEBOUNCE_CYCLES edges.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync_b[g] == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
                lvl <= ~lvl;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign db_lvl[g] = lvl;
    end

    assign d_db  = db_lvl[0];
    assign ld_db = db_lvl[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_prev <= 1'b0;
        end else begin
            ld_prev <= ld_db;
        end
    end

    assign ld_pulse = ld_db & ~ld_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            case (mode_s)
                MODE_LATCH: begin
                    if (ld_db) begin
                        q <= {q[WIDTH-1:1], d_db};
                    end
                end
                MODE_DFF: begin
                    if (ld_pulse) begin
                        q <= {q[WIDTH-1:1], d_db};
                    end
                end
                MODE_SHIFT: begin
                    if (ld_pulse) begin
                        q <= {q[WIDTH-2:0], d_db};
                    end
                end
                MODE_COUNTER: begin
                    if (ld_pulse) begin
                        q <= d_db ? (q + WIDTH'(1)) : (q - WIDTH'(1));
                    end
                end
                default: begin
                    q <= q;
                end
            endcase
        end
    end

    assign led = (LED_ACTIVE_LOW != 0) ? ~q : q;

endmodule

// File: tb/tb_storage_element_bank.sv
// Self-checking bench for storage_element_bank: directed checks of reset, debounce and
// each mode, then random press sequences compared against a press-level model.
module tb_storage_element_bank;

    localparam int W    = 6;
    localparam int DC   = 4;
    localparam int HOLD = DC + 4;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         btn_d    = 1'b0;
    logic         btn_load = 1'b0;
    logic [1:0]   mode     = 2'b00;
    logic [W-1:0] q;
    logic [W-1:0] led;

    int           total = 0;
    int           bad   = 0;
    int           seen;
    logic [W-1:0] m_q;
    logic [1:0]   r_mode;
    logic         r_d;
    logic [W-1:0] shift_exp [3];

    always #5 clk = ~clk;

    storage_element_bank #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC),
        .LED_ACTIVE_LOW (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_d   (btn_d),
        .btn_load(btn_load),
        .mode    (mode),
        .q       (q),
        .led     (led)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [W-1:0] exp);
        logic [W-1:0] exp_led;
        exp_led = ~exp;
        check_val(tag, 32'(q), 32'(exp));
        check_val({tag, "_led"}, 32'(led), 32'(exp_led));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_d(input logic v);
        btn_d = v;
        tick(HOLD);
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode = m;
        tick(3);
    endtask

    task automatic press();
        btn_load = 1'b1;
        tick(HOLD);
        btn_load = 1'b0;
        tick(HOLD);
    endtask

    // One completed press with d held steady: what each storage behaviour does to q.
    function automatic logic [W-1:0] model_press(input logic [1:0] m, input logic d,
                                                 input logic [W-1:0] cur);
        logic [W-1:0] nxt;
        nxt = cur;
        case (m)
            2'd0, 2'd1: nxt[0] = d;
            2'd2:       nxt = {cur[W-2:0], d};
            default:    nxt = d ? cur + 6'd1 : cur - 6'd1;
        endcase
        return nxt;
    endfunction

    initial begin
        shift_exp[0] = 6'h05;
        shift_exp[1] = 6'h0A;
        shift_exp[2] = 6'h15;

        tick(2);
        rst_n = 1'b1;
        tick(1);
        check_q("reset", 6'h00);

        // Short load glitch in dff mode with d=1 must not touch q
        set_mode(2'b01);
        set_d(1'b1);
        seen = 0;
        btn_load = 1'b1;
        for (int i = 0; i < 3 + HOLD; i++) begin
            if (i == 3) btn_load = 1'b0;
            @(negedge clk);
            seen = seen + int'(dut.ld_pulse) + int'(dut.ld_db);
        end
        check_val("glitch_pulses", 32'(seen), 32'd0);
        check_q("glitch_q", 6'h00);

        btn_load = 1'b1;
        tick(5);
        check_val("ld_db_edge5", 32'(dut.ld_db), 32'd0);
        tick(1);
        check_val("ld_db_edge6", 32'(dut.ld_db), 32'd1);
        check_val("pulse_on", 32'(dut.ld_pulse), 32'd1);
        tick(1);
        check_val("pulse_off", 32'(dut.ld_pulse), 32'd0);
        check_q("dff", 6'h01);
        tick(HOLD - 7);
        btn_load = 1'b0;
        tick(HOLD);

        set_mode(2'b10);
        set_d(1'b0);
        press();
        check_q("shift_0", 6'h02);
        for (int i = 0; i < 3; i++) begin
            set_d((i % 2) == 0);
            press();
            check_q("shift_seq", shift_exp[i]);
        end
        set_d(1'b0);
        press();
        check_q("shift_2a", 6'h2A);

        set_mode(2'b00);
        btn_load = 1'b1;
        tick(HOLD);
        check_q("latch_open", 6'h2A);
        btn_d = 1'b1;
        tick(6);
        check_q("latch_lag", 6'h2A);
        tick(1);
        check_q("latch_follow1", 6'h2B);
        tick(HOLD - 7);
        btn_d = 1'b0;
        tick(HOLD);
        check_q("latch_follow0", 6'h2A);
        btn_load = 1'b0;
        tick(HOLD);
        btn_d = 1'b1;
        tick(HOLD);
        check_q("latch_hold", 6'h2A);

        #3 rst_n = 1'b0;
        #1 check_q("async_reset", 6'h00);
        btn_d = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(HOLD);

        set_mode(2'b11);
        set_d(1'b0);
        press();
        check_q("count_down_wrap", 6'h3F);
        set_d(1'b1);
        press();
        check_q("count_up_wrap", 6'h00);

        set_mode(2'b01);
        btn_load = 1'b1;
        tick(HOLD);
        check_q("held_pre", 6'h01);
        #2 rst_n = 1'b0;
        tick(2);
        check_q("held_in_reset", 6'h00);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * HOLD; i++) begin
            @(negedge clk);
            seen = seen + int'(dut.ld_pulse);
        end
        check_val("held_pulses", 32'(seen), 32'd1);
        check_q("held_q", 6'h01);
        mode = 2'b10;
        tick(HOLD);
        check_q("mode_switch", 6'h01);
        btn_load = 1'b0;
        tick(HOLD);
        check_q("mode_release", 6'h01);

        m_q = 6'h01;
        for (int it = 0; it < 40; it++) begin
            r_mode = 2'($urandom_range(0, 3));
            r_d    = 1'($urandom_range(0, 1));
            set_mode(r_mode);
            set_d(r_d);
            if ($urandom_range(0, 1) == 1) begin
                btn_load = 1'b1;
                tick(int'($urandom_range(1, 3)));
                btn_load = 1'b0;
                tick(HOLD);
                check_q("rnd_glitch", m_q);
            end
            press();
            m_q = model_press(r_mode, r_d, m_q);
            check_q("rnd_press", m_q);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
